data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 133 +++++++++++++
 tb/tb_data_mem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-side memory responder: word-addressed RAM with byte enables plus a small
// MMIO block (64-bit timer/compare, GPIO, sticky status) on a zero-latency bus.
module data_mem_responder #(
    parameter logic [31:0] RAM_BASE  = 32'h2000_0000,
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [3:0]  BE,
    input  logic        MemWrite,
    output logic [31:0] RD,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic        timer_irq,
    output logic        bus_err
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

    localparam logic [2:0] SEL_MTIME_LO = 3'd0;
    localparam logic [2:0] SEL_MTIME_HI = 3'd1;
    localparam logic [2:0] SEL_CMP_LO   = 3'd2;
    localparam logic [2:0] SEL_CMP_HI   = 3'd3;
    localparam logic [2:0] SEL_GPIO_OUT = 3'd4;
    localparam logic [2:0] SEL_GPIO_IN  = 3'd5;
    localparam logic [2:0] SEL_STATUS   = 3'd6;

    logic [31:0] r_ram [RAM_WORDS];
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [31:0] r_gpio_out;
    logic [31:0] r_gpio_s1;
    logic [31:0] r_gpio_s2;
    logic [1:0]  r_status;

    logic [31:0]   w_ram_off;
    logic          w_ram_hit;
    logic [AW-1:0] w_ram_idx;
    logic          w_mmio_hit;
    logic [2:0]    w_sel;
    logic          w_wr;
    logic          w_mmio_wr;
    logic [1:0]    w_status_next;
    logic [31:0]   w_rd;

    // Unsigned offset wraps for addresses below RAM_BASE, so one compare covers both bounds.
    assign w_ram_off  = Addr - RAM_BASE;
    assign w_ram_hit  = w_ram_off < RAM_BYTES;
    assign w_ram_idx  = w_ram_off[AW+1:2];
    assign w_mmio_hit = Addr[31:5] == MMIO_BASE[31:5];
    assign w_sel      = Addr[4:2];
    assign w_wr       = MemWrite && n_rst;
    assign w_mmio_wr  = w_wr && w_mmio_hit;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        w_rd = '0;
        if (w_ram_hit) begin
            w_rd = r_ram[w_ram_idx];
        end else if (w_mmio_hit) begin
            case (w_sel)
                SEL_MTIME_LO: w_rd = r_mtime[31:0];
                SEL_MTIME_HI: w_rd = r_mtime[63:32];
                SEL_CMP_LO:   w_rd = r_mtimecmp[31:0];
                SEL_CMP_HI:   w_rd = r_mtimecmp[63:32];
                SEL_GPIO_OUT: w_rd = r_gpio_out;
                SEL_GPIO_IN:  w_rd = r_gpio_s2;
                SEL_STATUS:   w_rd = {30'd0, r_status};
                default:      w_rd = '0;
            endcase
        end
    end

    assign RD = w_rd;

    // Clear first, then set, so a coincident set event wins over W1C.
    always_comb begin
        w_status_next = r_status;
        if (w_mmio_wr && w_sel == SEL_STATUS && BE[0]) w_status_next = r_status & ~WD[1:0];
        if (r_mtime >= r_mtimecmp) w_status_next[0] = 1'b1;
        if (w_wr && !w_ram_hit && !w_mmio_hit) w_status_next[1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_gpio_out <= '0;
            r_gpio_s1  <= '0;
            r_gpio_s2  <= '0;
            r_status   <= '0;
        end else begin
            r_mtime   <= r_mtime + 64'd1;
            r_gpio_s1 <= gpio_in;
            r_gpio_s2 <= r_gpio_s1;
            r_status  <= w_status_next;
            if (w_mmio_wr && w_sel == SEL_CMP_LO)
                r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], WD, BE);
            if (w_mmio_wr && w_sel == SEL_CMP_HI)
                r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], WD, BE);
            if (w_mmio_wr && w_sel == SEL_GPIO_OUT)
                r_gpio_out <= f_merge(r_gpio_out, WD, BE);
        end
    end

    // RAM contents survive reset; only the write strobe is gated by it.
    always_ff @(posedge clk) begin
        if (w_wr && w_ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (BE[i]) r_ram[w_ram_idx][8*i +: 8] <= WD[8*i +: 8];
            end
        end
    end

    assign gpio_out  = r_gpio_out;
    assign timer_irq = r_status[0];
    assign bus_err   = r_status[1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM byte writes, same-cycle read, timer,
// bus error, GPIO synchronizer and mid-run reset, with hand-computed expectations.
module tb_data_mem_responder;

    logic        clk;
    logic        n_rst;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic [3:0]  BE;
    logic        MemWrite;
    logic [31:0] RD;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        timer_irq;
    logic        bus_err;

    int          total;
    int          bad;
    logic [63:0] exp_mtime;

    localparam logic [31:0] A_MTIME_LO = 32'h4000_0000;
    localparam logic [31:0] A_CMP_LO   = 32'h4000_0008;
    localparam logic [31:0] A_CMP_HI   = 32'h4000_000C;
    localparam logic [31:0] A_GPIO_OUT = 32'h4000_0010;
    localparam logic [31:0] A_GPIO_IN  = 32'h4000_0014;
    localparam logic [31:0] A_STATUS   = 32'h4000_0018;
    localparam logic [31:0] A_RSVD     = 32'h4000_001C;

    data_mem_responder dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .Addr      (Addr),
        .WD        (WD),
        .BE        (BE),
        .MemWrite  (MemWrite),
        .RD        (RD),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and track the expected timer value alongside the DUT.
    task automatic tick();
        @(posedge clk);
        #1;
        if (n_rst) exp_mtime = exp_mtime + 64'd1;
        else       exp_mtime = 64'd0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        Addr = a; WD = d; BE = be; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0; BE = 4'b0000;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Addr = a; MemWrite = 1'b0;
        #1;
        check(tag, RD, exp);
    endtask

    initial begin
        total = 0; bad = 0; exp_mtime = 64'd0;
        n_rst = 1'b0; Addr = '0; WD = '0; BE = '0; MemWrite = 1'b0; gpio_in = '0;
        tick();
        tick();
        n_rst = 1'b1;

        // Reset state, read in the first cycle after reset.
        rd_chk("rst_mtime_lo", A_MTIME_LO, 32'h0);
        rd_chk("rst_cmp_lo", A_CMP_LO, 32'hFFFF_FFFF);
        rd_chk("rst_cmp_hi", A_CMP_HI, 32'hFFFF_FFFF);
        check("rst_gpio_out", gpio_out, 32'h0);
        check("rst_irq", {31'd0, timer_irq}, 32'h0);
        check("rst_bus_err", {31'd0, bus_err}, 32'h0);

        // Timer compare and W1C interaction.
        wr(A_CMP_HI, 32'h0, 4'b1111);
        wr(A_CMP_LO, 32'd20, 4'b1111);
        while (exp_mtime < 64'd20) tick();
        rd_chk("tmr_mtime_20", A_MTIME_LO, 32'd20);
        check("tmr_irq_before", {31'd0, timer_irq}, 32'h0);
        tick();
        check("tmr_irq_set", {31'd0, timer_irq}, 32'h1);
        rd_chk("tmr_status_rd", A_STATUS, 32'h1);
        wr(A_STATUS, 32'h1, 4'b0001);
        check("tmr_set_wins", {31'd0, timer_irq}, 32'h1);
        wr(A_CMP_HI, 32'hFFFF_FFFF, 4'b1111);
        wr(A_STATUS, 32'h1, 4'b0001);
        check("tmr_w1c_clear", {31'd0, timer_irq}, 32'h0);

        // RAM byte-enable writes and address aliasing within a word.
        wr(32'h2000_0010, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h2000_0010, 32'h0000_AA00, 4'b0010);
        rd_chk("sw_merge", 32'h2000_0010, 32'hDEAD_AAEF);
        rd_chk("sw_alias", 32'h2000_0013, 32'hDEAD_AAEF);
        wr(32'h2000_0010, 32'h0000_0000, 4'b0000);
        rd_chk("sw_be_none", 32'h2000_0010, 32'hDEAD_AAEF);
        wr(32'h2000_0FFC, 32'hC0FF_EE01, 4'b1111);
        rd_chk("sw_last_word", 32'h2000_0FFC, 32'hC0FF_EE01);

        // Same-cycle write is invisible until the next cycle.
        wr(32'h2000_0000, 32'h1111_1111, 4'b1111);
        Addr = 32'h2000_0000; WD = 32'h1234_5678; BE = 4'b1111; MemWrite = 1'b1;
        #1;
        check("same_cycle_old", RD, 32'h1111_1111);
        tick();
        MemWrite = 1'b0; BE = 4'b0000;
        rd_chk("same_cycle_new", 32'h2000_0000, 32'h1234_5678);

        // Unmapped reads do not flag; unmapped writes do and stick.
        Addr = 32'h3000_0000;
        tick();
        check("unmapped_rd_noerr", {31'd0, bus_err}, 32'h0);
        rd_chk("unmapped_rd_zero", 32'h3000_0000, 32'h0);
        wr(A_MTIME_LO, 32'h0, 4'b1111);
        check("ro_write_noerr", {31'd0, bus_err}, 32'h0);
        wr(A_RSVD, 32'hFFFF_FFFF, 4'b1111);
        rd_chk("rsvd_reads_zero", A_RSVD, 32'h0);
        wr(32'h3000_0000, 32'h1, 4'b1111);
        check("berr_set", {31'd0, bus_err}, 32'h1);
        tick();
        check("berr_sticky", {31'd0, bus_err}, 32'h1);
        rd_chk("berr_rd_zero", 32'h3000_0000, 32'h0);
        rd_chk("berr_status", A_STATUS, 32'h2);
        wr(A_STATUS, 32'h2, 4'b0001);
        check("berr_w1c", {31'd0, bus_err}, 32'h0);
        wr(32'h2000_1000, 32'h1, 4'b1111);
        check("berr_ram_end", {31'd0, bus_err}, 32'h1);
        wr(A_STATUS, 32'h2, 4'b0000);
        check("berr_w1c_needs_be0", {31'd0, bus_err}, 32'h1);
        wr(A_STATUS, 32'h2, 4'b0001);
        wr(32'h1FFF_FFFC, 32'h1, 4'b1111);
        check("berr_below_ram", {31'd0, bus_err}, 32'h1);
        wr(A_STATUS, 32'h2, 4'b0001);
        check("berr_clear2", {31'd0, bus_err}, 32'h0);

        // GPIO synchronizer latency and byte-enabled output write.
        gpio_in = 32'hA5A5_0F0F;
        tick();
        rd_chk("gpio_in_1cyc", A_GPIO_IN, 32'h0);
        tick();
        rd_chk("gpio_in_2cyc", A_GPIO_IN, 32'hA5A5_0F0F);
        wr(A_GPIO_OUT, 32'hFFFF_FFFF, 4'b0001);
        check("gpio_out_be", gpio_out, 32'h0000_00FF);
        rd_chk("gpio_out_rd", A_GPIO_OUT, 32'h0000_00FF);

        // Mid-run reset with everything set and writes pending in the reset cycle.
        wr(A_GPIO_OUT, 32'h0000_0055, 4'b1111);
        wr(32'h3000_0004, 32'h0, 4'b1111);
        wr(A_CMP_HI, 32'h0, 4'b1111);
        tick();
        check("pre_rst_irq", {31'd0, timer_irq}, 32'h1);
        check("pre_rst_berr", {31'd0, bus_err}, 32'h1);
        while (exp_mtime < 64'd1000) tick();
        rd_chk("pre_rst_mtime", A_MTIME_LO, 32'd1000);
        check("pre_rst_gpio", gpio_out, 32'h55);
        n_rst = 1'b0;
        Addr = 32'h2000_0010; WD = 32'h0BAD_0BAD; BE = 4'b1111; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0; BE = 4'b0000;
        n_rst = 1'b1;
        rd_chk("mid_rst_mtime", A_MTIME_LO, 32'h0);
        check("mid_rst_gpio", gpio_out, 32'h0);
        check("mid_rst_irq", {31'd0, timer_irq}, 32'h0);
        check("mid_rst_berr", {31'd0, bus_err}, 32'h0);
        rd_chk("mid_rst_cmp_hi", A_CMP_HI, 32'hFFFF_FFFF);
        rd_chk("mid_rst_gpio_in", A_GPIO_IN, 32'h0);
        rd_chk("mid_rst_ram_kept", 32'h2000_0010, 32'hDEAD_AAEF);
        tick();
        rd_chk("post_rst_mtime", A_MTIME_LO, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
